// File: rtl/gfx_rom_arbiter.sv
// Round-robin arbiter sharing one graphics-ROM read port between N layer
// fetchers (0 = bg, 1 = fg, 2 = sprite). Arbitration is aligned to video
// timing: the round-robin pointer restarts at each hblank rise, requests still
// pending at that point are flagged as overrun, and vblank rise clears the flags.
//
// Handshakes:
//   req[i]/done[i]  : req[i] is a level held (with its addr slice stable) until
//                     the one-cycle done[i] pulse; rd_data is valid from the
//                     done cycle until the next completion.
//   rom_req/rom_ack : rom_req is a level held (with rom_addr stable) until a
//                     one-cycle rom_ack; rom_data is sampled in the ack cycle.
//                     rom_ack outside an outstanding access is ignored.
module gfx_rom_arbiter #(
    parameter int N  = 3,
    parameter int AW = 20,
    parameter int DW = 32,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hbl,
    input  logic            vbl,
    input  logic [N-1:0]    req,
    input  logic [N*AW-1:0] addr,
    output logic [N-1:0]    done,
    output logic [DW-1:0]   rd_data,
    output logic            rom_req,
    output logic [AW-1:0]   rom_addr,
    input  logic            rom_ack,
    input  logic [DW-1:0]   rom_data,
    output logic [N-1:0]    overrun,
    output logic [1:0]      dbg_state,
    output logic [PW-1:0]   dbg_ptr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] ptr, ptr_n;
    logic [PW-1:0] idx, idx_n;
    logic          rom_req_n;
    logic [AW-1:0] rom_addr_n;
    logic [N-1:0]  done_n;
    logic [DW-1:0] rd_data_n;
    logic [N-1:0]  overrun_n;
    logic          hbl_d, vbl_d;
    logic          hbl_rise, vbl_rise;
    logic          found;
    logic [PW-1:0] sel;
    logic [AW-1:0] sel_addr;
    logic          busy;

    assign hbl_rise  = hbl & ~hbl_d;
    assign vbl_rise  = vbl & ~vbl_d;
    assign busy      = (state == S_WAIT) || (state == S_DONE);
    assign dbg_state = state;
    assign dbg_ptr   = ptr;

    // Round-robin pick: first requester at or after ptr, wrapping explicitly mod N.
    always_comb begin : pick_blk
        int c;
        c     = 0;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr) + k;
            if (c >= N) c = c - N;
            if (!found && req[c]) begin
                found = 1'b1;
                sel   = PW'(c);
            end
        end
    end

    // Address slice of the selected requester.
    always_comb begin
        sel_addr = addr[int'(sel)*AW +: AW];
    end

    // Next-state and registered-output logic; video-timing effects applied last
    // so they override the ordinary pointer update.
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        idx_n      = idx;
        rom_req_n  = rom_req;
        rom_addr_n = rom_addr;
        done_n     = '0;
        rd_data_n  = rd_data;
        overrun_n  = overrun;

        case (state)
            S_IDLE: begin
                if (found) begin
                    idx_n      = sel;
                    rom_addr_n = sel_addr;
                    rom_req_n  = 1'b1;
                    state_n    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rom_ack) begin
                    rom_req_n   = 1'b0;
                    rd_data_n   = rom_data;
                    done_n[idx] = 1'b1;
                    ptr_n       = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
                    state_n     = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n   = S_IDLE;
                rom_req_n = 1'b0;
            end
        endcase

        if (hbl_rise) begin
            ptr_n = '0;
            for (int i = 0; i < N; i++) begin
                if (req[i] && !(busy && (idx == PW'(i)))) overrun_n[i] = 1'b1;
            end
        end

        // Frame start clears the flags, winning over a simultaneous hblank set.
        if (vbl_rise) overrun_n = '0;
    end

    // State register and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            ptr      <= '0;
            idx      <= '0;
            rom_req  <= 1'b0;
            rom_addr <= '0;
            done     <= '0;
            rd_data  <= '0;
            overrun  <= '0;
            hbl_d    <= 1'b0;
            vbl_d    <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            idx      <= idx_n;
            rom_req  <= rom_req_n;
            rom_addr <= rom_addr_n;
            done     <= done_n;
            rd_data  <= rd_data_n;
            overrun  <= overrun_n;
            hbl_d    <= hbl;
            vbl_d    <= vbl;
        end
    end

endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// Directed self-checking bench for gfx_rom_arbiter. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_gfx_rom_arbiter;

    localparam int N  = 3;
    localparam int AW = 20;
    localparam int DW = 32;
    localparam int PW = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;

    localparam logic [AW-1:0] A0 = 20'h12345;
    localparam logic [AW-1:0] A1 = 20'h0ABCD;
    localparam logic [AW-1:0] A2 = 20'hF0F0F;

    logic            clk = 1'b0;
    logic            reset;
    logic            hbl, vbl;
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    done;
    logic [DW-1:0]   rd_data;
    logic            rom_req;
    logic [AW-1:0]   rom_addr;
    logic            rom_ack;
    logic [DW-1:0]   rom_data;
    logic [N-1:0]    overrun;
    logic [1:0]      dbg_state;
    logic [PW-1:0]   dbg_ptr;

    int tests_run    = 0;
    int tests_failed = 0;

    gfx_rom_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .hbl(hbl), .vbl(vbl),
        .req(req), .addr(addr), .done(done), .rd_data(rd_data),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack),
        .rom_data(rom_data), .overrun(overrun),
        .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
    );

    // Clock
    always #5 clk = ~clk;

    // Driver: synchronous reset for two cycles with all inputs idle.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; hbl = 1'b0; vbl = 1'b0; req = '0; rom_ack = 1'b0; rom_data = '0;
        addr = {A2, A1, A0};
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (rom_req !== 1'b0) begin tests_failed++; $display("FAIL reset_rom_req got %b exp 0", rom_req); end
        tests_run++; if (rom_addr !== '0) begin tests_failed++; $display("FAIL reset_rom_addr got %h exp 0", rom_addr); end
        tests_run++; if (done !== 3'b000) begin tests_failed++; $display("FAIL reset_done got %b exp 000", done); end
        tests_run++; if (rd_data !== '0) begin tests_failed++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
        tests_run++; if (overrun !== 3'b000) begin tests_failed++; $display("FAIL reset_overrun got %b exp 000", overrun); end
        tests_run++; if (dbg_state !== ST_IDLE || dbg_ptr !== 2'd0) begin tests_failed++; $display("FAIL reset_state got st=%0d ptr=%0d exp 0/0", dbg_state, dbg_ptr); end
    endtask

    task automatic test_single();
        do_reset();
        req = 3'b001;
        @(negedge clk);
        tests_run++; if (rom_req !== 1'b1) begin tests_failed++; $display("FAIL single_rom_req got %b exp 1", rom_req); end
        tests_run++; if (rom_addr !== A0) begin tests_failed++; $display("FAIL single_rom_addr got %h exp %h", rom_addr, A0); end
        @(negedge clk);
        tests_run++; if (rom_req !== 1'b1 || done !== 3'b000) begin tests_failed++; $display("FAIL single_hold got req=%b done=%b exp 1/000", rom_req, done); end
        rom_ack = 1'b1; rom_data = 32'hDEADBEEF;
        @(negedge clk);
        rom_ack = 1'b0; req = 3'b000;
        tests_run++; if (done !== 3'b001) begin tests_failed++; $display("FAIL single_done got %b exp 001", done); end
        tests_run++; if (rd_data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL single_rd_data got %h exp deadbeef", rd_data); end
        tests_run++; if (rom_req !== 1'b0) begin tests_failed++; $display("FAIL single_rom_req_drop got %b exp 0", rom_req); end
        @(negedge clk);
        tests_run++; if (done !== 3'b000 || dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL single_done_width got done=%b st=%0d exp 000/0", done, dbg_state); end
        tests_run++; if (rd_data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL single_rd_hold got %h exp deadbeef", rd_data); end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] exp_addr;
        int            g_idx;
        do_reset();
        req = 3'b111;
        for (int g = 0; g < 6; g++) begin
            g_idx    = g % 3;
            exp_addr = (g_idx == 0) ? A0 : (g_idx == 1) ? A1 : A2;
            @(negedge clk);
            tests_run++; if (rom_req !== 1'b1 || rom_addr !== exp_addr) begin tests_failed++; $display("FAIL rr_grant%0d got req=%b addr=%h exp 1/%h", g, rom_req, rom_addr, exp_addr); end
            rom_ack = 1'b1; rom_data = 32'hA0000000 + 32'(g);
            @(negedge clk);
            rom_ack = 1'b0;
            tests_run++; if (done !== 3'(1 << g_idx) || rd_data !== 32'hA0000000 + 32'(g)) begin tests_failed++; $display("FAIL rr_done%0d got done=%b data=%h exp %b/%h", g, done, rd_data, 3'(1 << g_idx), 32'hA0000000 + 32'(g)); end
            @(negedge clk);
            tests_run++; if (done !== 3'b000 || rom_req !== 1'b0) begin tests_failed++; $display("FAIL rr_gap%0d got done=%b req=%b exp 000/0", g, done, rom_req); end
        end
        req = 3'b000;
    endtask

    task automatic test_hblank();
        do_reset();
        req = 3'b111;
        // Serve requester 0.
        @(negedge clk); rom_ack = 1'b1; rom_data = 32'h1;
        @(negedge clk); rom_ack = 1'b0;
        @(negedge clk);
        // Requester 1 in WAIT; hblank rises in its ack cycle.
        @(negedge clk);
        tests_run++; if (rom_addr !== A1) begin tests_failed++; $display("FAIL hbl_serving got %h exp %h", rom_addr, A1); end
        hbl = 1'b1; rom_ack = 1'b1; rom_data = 32'h2222;
        @(negedge clk);
        rom_ack = 1'b0;
        tests_run++; if (done !== 3'b010 || rd_data !== 32'h2222) begin tests_failed++; $display("FAIL hbl_complete got done=%b data=%h exp 010/2222", done, rd_data); end
        tests_run++; if (overrun !== 3'b101) begin tests_failed++; $display("FAIL hbl_overrun got %b exp 101", overrun); end
        tests_run++; if (dbg_ptr !== 2'd0) begin tests_failed++; $display("FAIL hbl_ptr got %0d exp 0", dbg_ptr); end
        @(negedge clk);
        @(negedge clk);
        tests_run++; if (rom_req !== 1'b1 || rom_addr !== A0) begin tests_failed++; $display("FAIL hbl_next_grant got req=%b addr=%h exp 1/%h", rom_req, rom_addr, A0); end
        rom_ack = 1'b1;
        @(negedge clk); rom_ack = 1'b0; req = 3'b000;
        @(negedge clk);
        tests_run++; if (overrun !== 3'b101) begin tests_failed++; $display("FAIL hbl_sticky got %b exp 101", overrun); end
        vbl = 1'b1;
        @(negedge clk);
        tests_run++; if (overrun !== 3'b000) begin tests_failed++; $display("FAIL vbl_clear got %b exp 000", overrun); end
        hbl = 1'b0; vbl = 1'b0;
    endtask

    task automatic test_drop_in_wait();
        do_reset();
        req = 3'b100;
        @(negedge clk);
        tests_run++; if (rom_addr !== A2) begin tests_failed++; $display("FAIL drop_grant got %h exp %h", rom_addr, A2); end
        req = 3'b001; rom_ack = 1'b1; rom_data = 32'h5A5A5A5A;
        @(negedge clk);
        rom_ack = 1'b0;
        tests_run++; if (done !== 3'b100 || rd_data !== 32'h5A5A5A5A) begin tests_failed++; $display("FAIL drop_done got done=%b data=%h exp 100/5a5a5a5a", done, rd_data); end
        @(negedge clk);
        @(negedge clk);
        tests_run++; if (rom_req !== 1'b1 || rom_addr !== A0) begin tests_failed++; $display("FAIL drop_next got req=%b addr=%h exp 1/%h", rom_req, rom_addr, A0); end
        req = 3'b000; rom_ack = 1'b1;
        @(negedge clk); rom_ack = 1'b0;
        tests_run++; if (done !== 3'b001) begin tests_failed++; $display("FAIL drop_next_done got %b exp 001", done); end
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        req = 3'b001;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; req = 3'b000; rom_ack = 1'b1; rom_data = 32'hCAFEF00D;
        tests_run++; if (rom_req !== 1'b0 || dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL rst_mid_drop got req=%b st=%0d exp 0/0", rom_req, dbg_state); end
        @(negedge clk);
        rom_ack = 1'b0;
        tests_run++; if (done !== 3'b000 || rd_data !== '0) begin tests_failed++; $display("FAIL rst_stray_ack got done=%b data=%h exp 000/0", done, rd_data); end
        tests_run++; if (dbg_state !== ST_IDLE || rom_req !== 1'b0) begin tests_failed++; $display("FAIL rst_stray_state got st=%0d req=%b exp 0/0", dbg_state, rom_req); end
    endtask

    task automatic test_hbl_vbl_same_cycle();
        do_reset();
        req = 3'b001;
        @(negedge clk); rom_ack = 1'b1;
        @(negedge clk); rom_ack = 1'b0; req = 3'b000;
        @(negedge clk);
        tests_run++; if (dbg_ptr !== 2'd1) begin tests_failed++; $display("FAIL both_pre_ptr got %0d exp 1", dbg_ptr); end
        req = 3'b010; hbl = 1'b1; vbl = 1'b1;
        @(negedge clk);
        tests_run++; if (overrun !== 3'b000) begin tests_failed++; $display("FAIL both_overrun got %b exp 000", overrun); end
        tests_run++; if (dbg_ptr !== 2'd0 || dbg_state !== ST_WAIT) begin tests_failed++; $display("FAIL both_ptr got ptr=%0d st=%0d exp 0/1", dbg_ptr, dbg_state); end
        rom_ack = 1'b1;
        @(negedge clk); rom_ack = 1'b0; req = 3'b000; hbl = 1'b0; vbl = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; hbl = 1'b0; vbl = 1'b0; req = '0; addr = '0;
        rom_ack = 1'b0; rom_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_hblank();
        test_drop_in_wait();
        test_reset_mid_access();
        test_hbl_vbl_same_cycle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
